// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants and FSM state type for the UART command sequencer.
package uart_cmd_sequencer_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned ADDR_OP_A = 0;
   localparam int unsigned ADDR_OP_B = 1;

   typedef enum logic [3:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StRdAddr,
      StRdWait,
      StRdSend,
      StAluA,
      StAluB,
      StAluFun,
      StAluWait,
      StSendLo,
      StSendHi
   } seq_state_e;

endpackage

// File: rtl/uart_cmd_sequencer_tx_byte_pusher.sv
// Holds up to two response bytes and pushes them, low byte first, into the TX FIFO.
module uart_cmd_sequencer_tx_byte_pusher #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    load,
   input  logic                    load_two,
   input  logic [2*DATA_WIDTH-1:0] load_data,
   input  logic                    FIFO_FULL,
   output logic [1:0]              pending,
   output logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic                    WR_INC
);

   logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    wr_inc_q, wr_inc_d;

   // A push cycle is always followed by an idle cycle so consecutive pushes stay
   // distinct pulses and FIFO_FULL has a cycle to reflect the previous push.
   always_comb begin
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      wr_data_d = wr_data_q;
      wr_inc_d  = 1'b0;
      if (load) begin
         buf_d = load_data;
         cnt_d = load_two ? 2'd2 : 2'd1;
      end else if ((cnt_q != 2'd0) && !FIFO_FULL && !wr_inc_q) begin
         wr_inc_d  = 1'b1;
         wr_data_d = buf_q[DATA_WIDTH-1:0];
         buf_d     = {{DATA_WIDTH{1'b0}}, buf_q[2*DATA_WIDTH-1:DATA_WIDTH]};
         cnt_d     = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         buf_q     <= '0;
         cnt_q     <= 2'd0;
         wr_data_q <= '0;
         wr_inc_q  <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         wr_data_q <= wr_data_d;
         wr_inc_q  <= wr_inc_d;
      end
   end

   assign pending = cnt_q;
   assign WR_DATA = wr_data_q;
   assign WR_INC  = wr_inc_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Decodes UART command frames into register-file accesses and ALU operations,
// returning results through the TX FIFO.
module uart_cmd_sequencer
   import uart_cmd_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned FUN_WIDTH     = 4,
   parameter int unsigned ALU_OUT_WIDTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]    RdData,
   input  logic                     RdData_Valid,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     OUT_Valid,
   input  logic                     FIFO_FULL,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [ADDR_WIDTH-1:0]    Address,
   output logic [DATA_WIDTH-1:0]    WrData,
   output logic                     ALU_EN,
   output logic [FUN_WIDTH-1:0]     ALU_FUN,
   output logic                     CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]    WR_DATA,
   output logic                     WR_INC
);

   seq_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  alu_en_q, alu_en_d;
   logic                  clk_gate_q, clk_gate_d;

   logic                     push_load;
   logic                     push_two;
   logic [ALU_OUT_WIDTH-1:0] push_data;
   logic [1:0]               pending;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      alu_fun_d = alu_fun_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      push_load = 1'b0;
      push_two  = 1'b0;
      push_data = '0;

      unique case (state_q)
         StIdle: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  CMD_RF_WR:   state_d = StWrAddr;
                  CMD_RF_RD:   state_d = StRdAddr;
                  CMD_ALU_OP:  state_d = StAluA;
                  CMD_ALU_NOP: state_d = StAluFun;
                  default:     state_d = StIdle;
               endcase
            end
         end
         StWrAddr: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = StWrData;
            end
         end
         StWrData: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               wr_data_d = RX_P_DATA;
               state_d   = StIdle;
            end
         end
         StRdAddr: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_d = 1'b1;
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (RdData_Valid) begin
               push_load = 1'b1;
               push_data = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, RdData};
               state_d   = StRdSend;
            end
         end
         StRdSend: begin
            if (pending == 2'd0) state_d = StIdle;
         end
         StAluA: begin
            if (RX_D_VLD) begin
               addr_d    = ADDR_WIDTH'(ADDR_OP_A);
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = StAluB;
            end
         end
         StAluB: begin
            if (RX_D_VLD) begin
               addr_d    = ADDR_WIDTH'(ADDR_OP_B);
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = StAluFun;
            end
         end
         StAluFun: begin
            if (RX_D_VLD) begin
               alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
               alu_en_d  = 1'b1;
               state_d   = StAluWait;
            end
         end
         StAluWait: begin
            if (OUT_Valid) begin
               push_load = 1'b1;
               push_two  = 1'b1;
               push_data = ALU_OUT;
               state_d   = StSendLo;
            end
         end
         // The pusher counts down as it drains; these states track that count.
         StSendLo: begin
            if (pending == 2'd1) state_d = StSendHi;
         end
         StSendHi: begin
            if (pending == 2'd0) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      clk_gate_d = (state_d == StAluFun) || (state_d == StAluWait) ||
                   (state_d == StSendLo) || (state_d == StSendHi);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wr_data_q  <= '0;
         alu_fun_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         alu_en_q   <= 1'b0;
         clk_gate_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         alu_fun_q  <= alu_fun_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         alu_en_q   <= alu_en_d;
         clk_gate_q <= clk_gate_d;
      end
   end

   uart_cmd_sequencer_tx_byte_pusher #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx_byte_pusher (
      .CLK       (CLK),
      .RST       (RST),
      .load      (push_load),
      .load_two  (push_two),
      .load_data (push_data),
      .FIFO_FULL (FIFO_FULL),
      .pending   (pending),
      .WR_DATA   (WR_DATA),
      .WR_INC    (WR_INC)
   );

   assign WrEn        = wr_en_q;
   assign RdEn        = rd_en_q;
   assign Address     = addr_q;
   assign WrData      = wr_data_q;
   assign ALU_EN      = alu_en_q;
   assign ALU_FUN     = alu_fun_q;
   assign CLK_GATE_EN = clk_gate_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: logs every strobe and checks frames one scenario at a time.
module tb_uart_cmd_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  RdData = '0;
   logic        RdData_Valid = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        OUT_Valid = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, WR_INC;
   logic [3:0]  Address, ALU_FUN;
   logic [7:0]  WrData, WR_DATA;

   uart_cmd_sequencer dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_P_DATA    (RX_P_DATA),
      .RX_D_VLD     (RX_D_VLD),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .ALU_OUT      (ALU_OUT),
      .OUT_Valid    (OUT_Valid),
      .FIFO_FULL    (FIFO_FULL),
      .WrEn         (WrEn),
      .RdEn         (RdEn),
      .Address      (Address),
      .WrData       (WrData),
      .ALU_EN       (ALU_EN),
      .ALU_FUN      (ALU_FUN),
      .CLK_GATE_EN  (CLK_GATE_EN),
      .WR_DATA      (WR_DATA),
      .WR_INC       (WR_INC)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   ev_t wr_q[$], rd_q[$], alu_q[$], push_q[$];
   int  total = 0, bad = 0, cyc = 0, last_cyc = 0;
   int  full_viol = 0, width_viol = 0;
   logic prev_wr = 1'b0, prev_rd = 1'b0, prev_alu = 1'b0, prev_inc = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Strobe monitor: outputs are sampled half a cycle after the active edge.
   always @(negedge CLK) begin
      if (WrEn)   wr_q.push_back('{cyc, 8'(Address), WrData});
      if (RdEn)   rd_q.push_back('{cyc, 8'(Address), 8'h00});
      if (ALU_EN) alu_q.push_back('{cyc, 8'h00, 8'(ALU_FUN)});
      if (WR_INC) push_q.push_back('{cyc, 8'h00, WR_DATA});
      if (WR_INC && FIFO_FULL) full_viol <= full_viol + 1;
      if ((WrEn && prev_wr) || (RdEn && prev_rd) || (ALU_EN && prev_alu) || (WR_INC && prev_inc))
         width_viol <= width_viol + 1;
      prev_wr  <= WrEn;
      prev_rd  <= RdEn;
      prev_alu <= ALU_EN;
      prev_inc <= WR_INC;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      alu_q.delete();
      push_q.delete();
   endtask

   // Presents one byte for one cycle; last_cyc is the cycle its strobe should appear in.
   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'h00;
      last_cyc  = cyc;
   endtask

   task automatic wait_pushes(input int n, input int budget);
      for (int i = 0; i < budget && push_q.size() < n; i++) @(negedge CLK);
   endtask

   task automatic test_reset();
      logic [29:0] outs;
      RST = 1'b0;
      idle(3);
      outs = {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, WR_DATA, WR_INC};
      total++;
      if (outs !== 30'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      @(negedge CLK);
      RST = 1'b1;
      idle(2);
   endtask

   task automatic test_write();
      int exp_cyc;
      clear_logs();
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h3C);
      exp_cyc = last_cyc;
      idle(4);
      total++;
      if (wr_q.size() != 1 || wr_q[0].a !== 8'h05 || wr_q[0].d !== 8'h3C) begin
         bad++;
         $display("FAIL write_strobe: got %0d writes (first a=%h d=%h) expected 1 write a=05 d=3c",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0].a : 8'hxx,
                  (wr_q.size() > 0) ? wr_q[0].d : 8'hxx);
      end
      total++;
      if (wr_q.size() != 1 || wr_q[0].cyc != exp_cyc) begin
         bad++;
         $display("FAIL write_latency: got cycle %0d expected %0d",
                  (wr_q.size() > 0) ? wr_q[0].cyc : -1, exp_cyc);
      end
      total++;
      if (push_q.size() != 0 || rd_q.size() != 0) begin
         bad++;
         $display("FAIL write_no_side: got pushes=%0d reads=%0d expected 0 0",
                  push_q.size(), rd_q.size());
      end
   endtask

   task automatic test_read();
      int exp_cyc;
      clear_logs();
      send_byte(8'hBB);
      send_byte(8'h05);
      exp_cyc = last_cyc;
      @(negedge CLK);
      @(negedge CLK);
      RdData       = 8'h3C;
      RdData_Valid = 1'b1;
      @(negedge CLK);
      RdData_Valid = 1'b0;
      RdData       = 8'h00;
      wait_pushes(1, 30);
      idle(4);
      total++;
      if (rd_q.size() != 1 || rd_q[0].a !== 8'h05 || rd_q[0].cyc != exp_cyc) begin
         bad++;
         $display("FAIL read_strobe: got %0d reads (first a=%h cyc=%0d) expected 1 a=05 cyc=%0d",
                  rd_q.size(), (rd_q.size() > 0) ? rd_q[0].a : 8'hxx,
                  (rd_q.size() > 0) ? rd_q[0].cyc : -1, exp_cyc);
      end
      total++;
      if (push_q.size() != 1 || push_q[0].d !== 8'h3C) begin
         bad++;
         $display("FAIL read_push: got %0d pushes (first %h) expected 1 push 3c",
                  push_q.size(), (push_q.size() > 0) ? push_q[0].d : 8'hxx);
      end
      total++;
      if (wr_q.size() != 0) begin
         bad++;
         $display("FAIL read_no_write: got %0d writes expected 0", wr_q.size());
      end
   endtask

   task automatic test_alu_op();
      int cg_low = 0;
      clear_logs();
      send_byte(8'hCC);
      send_byte(8'h12);
      send_byte(8'h34);
      idle(1);
      total++;
      if (CLK_GATE_EN !== 1'b1) begin
         bad++;
         $display("FAIL alu_gate_on: got %b expected 1", CLK_GATE_EN);
      end
      send_byte(8'h00);
      idle(2);
      @(negedge CLK);
      ALU_OUT   = 16'h0046;
      OUT_Valid = 1'b1;
      @(negedge CLK);
      OUT_Valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         #1;
         if (push_q.size() >= 2) break;
         if (!CLK_GATE_EN) cg_low++;
      end
      idle(3);
      total++;
      if (wr_q.size() != 2 || wr_q[0].a !== 8'h00 || wr_q[0].d !== 8'h12 ||
          wr_q[1].a !== 8'h01 || wr_q[1].d !== 8'h34) begin
         bad++;
         $display("FAIL alu_operand_writes: got %0d writes expected (00,12) then (01,34)",
                  wr_q.size());
      end
      total++;
      if (alu_q.size() != 1 || alu_q[0].d !== 8'h00) begin
         bad++;
         $display("FAIL alu_en_fun: got %0d ALU_EN pulses expected 1 with fun 0", alu_q.size());
      end
      total++;
      if (push_q.size() != 2 || push_q[0].d !== 8'h46 || push_q[1].d !== 8'h00) begin
         bad++;
         $display("FAIL alu_pushes: got %0d pushes expected 46 then 00", push_q.size());
      end
      total++;
      if (cg_low != 0) begin
         bad++;
         $display("FAIL alu_gate_hold: got %0d low cycles expected 0", cg_low);
      end
      total++;
      if (CLK_GATE_EN !== 1'b0) begin
         bad++;
         $display("FAIL alu_gate_off: got %b expected 0", CLK_GATE_EN);
      end
   endtask

   task automatic test_alu_nop_full();
      int full_pushes = 0;
      clear_logs();
      send_byte(8'hDD);
      send_byte(8'h02);
      send_byte(8'hAA);  // arrives in ALU_WAIT and must be dropped
      @(negedge CLK);
      ALU_OUT   = 16'hABCD;
      OUT_Valid = 1'b1;
      FIFO_FULL = 1'b1;
      @(negedge CLK);
      OUT_Valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         #1;
         if (WR_INC) full_pushes++;
      end
      @(negedge CLK);
      FIFO_FULL = 1'b0;
      wait_pushes(2, 30);
      idle(4);
      total++;
      if (full_pushes != 0) begin
         bad++;
         $display("FAIL nop_hold_full: got %0d pushes while full expected 0", full_pushes);
      end
      total++;
      if (push_q.size() != 2 || push_q[0].d !== 8'hCD || push_q[1].d !== 8'hAB) begin
         bad++;
         $display("FAIL nop_pushes: got %0d pushes (first %h) expected cd then ab",
                  push_q.size(), (push_q.size() > 0) ? push_q[0].d : 8'hxx);
      end
      total++;
      if (alu_q.size() != 1 || alu_q[0].d !== 8'h02 || wr_q.size() != 0) begin
         bad++;
         $display("FAIL nop_alu: got %0d ALU_EN, %0d writes expected 1 ALU_EN fun 2, 0 writes",
                  alu_q.size(), wr_q.size());
      end
   endtask

   task automatic test_unknown();
      clear_logs();
      send_byte(8'h55);
      idle(3);
      total++;
      if (wr_q.size() + rd_q.size() + alu_q.size() + push_q.size() != 0 || CLK_GATE_EN !== 1'b0)
      begin
         bad++;
         $display("FAIL unknown_ignored: got %0d strobes gate=%b expected 0 strobes gate=0",
                  wr_q.size() + rd_q.size() + alu_q.size() + push_q.size(), CLK_GATE_EN);
      end
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'hFF);
      idle(3);
      total++;
      if (wr_q.size() != 1 || wr_q[0].a !== 8'h01 || wr_q[0].d !== 8'hFF) begin
         bad++;
         $display("FAIL unknown_then_write: got %0d writes expected 1 write a=01 d=ff",
                  wr_q.size());
      end
      total++;
      if (Address !== 4'h1 || WrData !== 8'hFF) begin
         bad++;
         $display("FAIL unknown_hold_regs: got Address=%h WrData=%h expected 1 ff",
                  Address, WrData);
      end
   endtask

   task automatic test_reset_mid();
      logic [29:0] outs;
      clear_logs();
      send_byte(8'hDD);
      send_byte(8'h07);
      idle(2);
      total++;
      if (CLK_GATE_EN !== 1'b1 || ALU_FUN !== 4'h7) begin
         bad++;
         $display("FAIL mid_pre_reset: got gate=%b fun=%h expected 1 7", CLK_GATE_EN, ALU_FUN);
      end
      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      outs = {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, WR_DATA, WR_INC};
      total++;
      if (outs !== 30'd0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %h expected 0", outs);
      end
      @(negedge CLK);
      RST = 1'b1;
      idle(2);
      clear_logs();
      send_byte(8'hBB);
      send_byte(8'h01);
      @(negedge CLK);
      RdData       = 8'h5A;
      RdData_Valid = 1'b1;
      @(negedge CLK);
      RdData_Valid = 1'b0;
      wait_pushes(1, 30);
      idle(4);
      total++;
      if (rd_q.size() != 1 || rd_q[0].a !== 8'h01 || push_q.size() != 1 || push_q[0].d !== 8'h5A)
      begin
         bad++;
         $display("FAIL mid_read_after: got reads=%0d pushes=%0d expected 1 read a=01, push 5a",
                  rd_q.size(), push_q.size());
      end
   endtask

   task automatic test_protocol();
      total++;
      if (full_viol != 0) begin
         bad++;
         $display("FAIL push_while_full: got %0d expected 0", full_viol);
      end
      total++;
      if (width_viol != 0) begin
         bad++;
         $display("FAIL strobe_width: got %0d wide strobes expected 0", width_viol);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_alu_op();
      test_alu_nop_full();
      test_unknown();
      test_reset_mid();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
